// File: rtl/f6_fc_mac.sv
// F6 fully connected MAC: holds the C5 feature vector, accumulates one signed dot product per neuron.
// Optional F6_RELU_EN adds a registered ReLU stage (latency 3 instead of 2).
module f6_fc_mac #(
    parameter int WD  = 8,
    parameter int NW  = 120,
    parameter int NUM = 84,
    parameter int AW  = 24
) (
    input  logic          i_sclk,
    input  logic          i_rst,
    input  logic          i_x_en,
    input  logic [7:0]    i_x_addr,
    input  logic [WD-1:0] i_x_data,
    input  logic          i_w_en,
    input  logic [7:0]    i_w_num,
    input  logic [7:0]    i_w_addr,
    input  logic [WD-1:0] i_weight,
    output logic          o_x_ready,
    output logic          o_y_valid,
    output logic [7:0]    o_y_num,
    output logic [AW-1:0] o_y_data,
    output logic          o_layer_done,
    output logic          o_err
);
    localparam int XIW = (NW > 1) ? $clog2(NW) : 1;
    localparam logic [7:0] NW8       = 8'(NW);
    localparam logic [7:0] LAST_ADDR = 8'(NW - 1);
    localparam logic [7:0] NUM8      = 8'(NUM);

    typedef enum logic [1:0] {LOAD, RUN, DONE} state_t;

    state_t          state_reg, state_next;
    logic [7:0]      x_cnt_reg, x_cnt_next;
    logic [7:0]      exp_num_reg, exp_num_next;
    logic            err_reg, err_next;

    logic signed [WD-1:0] feat [NW];
    logic signed [WD-1:0] feat_rd;
    logic [XIW-1:0]       x_idx, w_idx;
    logic                 x_beat_load, w_beat_run, w_first, w_last;
    logic                 layer_done;

    logic                   s1_valid_reg, s1_first_reg, s1_last_reg, s1_done_reg;
    logic [7:0]             s1_num_reg;
    logic signed [2*WD-1:0] s1_prod_reg;
    logic                   s2_valid_reg, s2_done_reg;
    logic [7:0]             s2_num_reg;
    logic [AW-1:0]          acc_reg;
    logic [AW-1:0]          prod_ext;

    assign x_idx       = i_x_addr[XIW-1:0];
    assign w_idx       = i_w_addr[XIW-1:0];
    assign x_beat_load = i_x_en && (state_reg == LOAD);
    assign w_beat_run  = i_w_en && (state_reg == RUN);
    assign w_first     = (i_w_addr == 8'd0);
    assign w_last      = (i_w_addr == LAST_ADDR);
    // Out-of-range weight addresses multiply against zero rather than an undefined entry.
    assign feat_rd     = (i_w_addr < NW8) ? feat[w_idx] : '0;
    assign prod_ext    = {{(AW-2*WD){s1_prod_reg[2*WD-1]}}, s1_prod_reg};

    always_ff @(posedge i_sclk) begin
        if (x_beat_load && (i_x_addr < NW8)) begin
            feat[x_idx] <= i_x_data;
        end
    end

    always_ff @(posedge i_sclk or posedge i_rst) begin
        if (i_rst) begin
            state_reg   <= LOAD;
            x_cnt_reg   <= 8'd0;
            exp_num_reg <= 8'd1;
            err_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            x_cnt_reg   <= x_cnt_next;
            exp_num_reg <= exp_num_next;
            err_reg     <= err_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        x_cnt_next   = x_cnt_reg;
        exp_num_next = exp_num_reg;
        err_next     = err_reg;
        case (state_reg)
            LOAD: begin
                if (i_x_en) begin
                    if (x_cnt_reg == LAST_ADDR) begin
                        x_cnt_next = 8'd0;
                        state_next = RUN;
                    end else begin
                        x_cnt_next = x_cnt_reg + 8'd1;
                    end
                    if (i_x_addr >= NW8) err_next = 1'b1;
                end
                if (i_w_en) err_next = 1'b1;
            end
            RUN: begin
                if (i_x_en) err_next = 1'b1;
                if (i_w_en) begin
                    if (w_first && (i_w_num != exp_num_reg)) err_next = 1'b1;
                    if (w_last) begin
                        if (exp_num_reg == NUM8) begin
                            exp_num_next = 8'd1;
                            state_next   = DONE;
                        end else begin
                            exp_num_next = exp_num_reg + 8'd1;
                        end
                    end
                end
            end
            DONE: begin
                // Features may only be reloaded once the layer has drained.
                if (i_x_en || i_w_en) err_next = 1'b1;
                if (layer_done) state_next = LOAD;
            end
            default: state_next = LOAD;
        endcase
    end

    always_ff @(posedge i_sclk or posedge i_rst) begin
        if (i_rst) begin
            s1_valid_reg <= 1'b0;
            s1_first_reg <= 1'b0;
            s1_last_reg  <= 1'b0;
            s1_done_reg  <= 1'b0;
            s1_num_reg   <= 8'd0;
            s1_prod_reg  <= '0;
            s2_valid_reg <= 1'b0;
            s2_done_reg  <= 1'b0;
            s2_num_reg   <= 8'd0;
            acc_reg      <= '0;
        end else begin
            s1_valid_reg <= w_beat_run;
            if (w_beat_run) begin
                s1_prod_reg  <= feat_rd * $signed(i_weight);
                s1_first_reg <= w_first;
                s1_last_reg  <= w_last;
                s1_done_reg  <= w_last && (exp_num_reg == NUM8);
                s1_num_reg   <= i_w_num;
            end
            s2_valid_reg <= s1_valid_reg && s1_last_reg;
            s2_done_reg  <= s1_valid_reg && s1_last_reg && s1_done_reg;
            if (s1_valid_reg) begin
                acc_reg    <= s1_first_reg ? prod_ext : acc_reg + prod_ext;
                s2_num_reg <= s1_num_reg;
            end
        end
    end

`ifdef F6_RELU_EN
    logic          y_valid_reg, y_done_reg;
    logic [7:0]    y_num_reg;
    logic [AW-1:0] y_data_reg;

    always_ff @(posedge i_sclk or posedge i_rst) begin
        if (i_rst) begin
            y_valid_reg <= 1'b0;
            y_done_reg  <= 1'b0;
            y_num_reg   <= 8'd0;
            y_data_reg  <= '0;
        end else begin
            y_valid_reg <= s2_valid_reg;
            y_done_reg  <= s2_done_reg;
            if (s2_valid_reg) begin
                y_num_reg  <= s2_num_reg;
                y_data_reg <= acc_reg[AW-1] ? '0 : acc_reg;
            end
        end
    end

    assign o_y_valid    = y_valid_reg;
    assign o_y_num      = y_num_reg;
    assign o_y_data     = y_data_reg;
    assign layer_done   = y_done_reg;
`else
    assign o_y_valid    = s2_valid_reg;
    assign o_y_num      = s2_num_reg;
    assign o_y_data     = acc_reg;
    assign layer_done   = s2_done_reg;
`endif

    assign o_layer_done = layer_done;
    assign o_x_ready    = (state_reg == LOAD);
    assign o_err        = err_reg;
endmodule

// File: tb/tb_f6_fc_mac.sv
// Bench for f6_fc_mac: random layers scored against an arithmetic dot-product model.
// Build with +define+F6_RELU_EN to exercise the ReLU variant.
module tb_f6_fc_mac;
    localparam int WD  = 8;
    localparam int NW  = 120;
    localparam int NUM = 84;
    localparam int AW  = 24;
`ifdef F6_RELU_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic          clk, rst;
    logic          x_en, w_en;
    logic [7:0]    x_addr, w_num, w_addr;
    logic [WD-1:0] x_data, weight;
    logic          x_ready, y_valid, layer_done, err;
    logic [7:0]    y_num;
    logic [AW-1:0] y_data;

    f6_fc_mac #(.WD(WD), .NW(NW), .NUM(NUM), .AW(AW)) dut (
        .i_sclk(clk), .i_rst(rst),
        .i_x_en(x_en), .i_x_addr(x_addr), .i_x_data(x_data),
        .i_w_en(w_en), .i_w_num(w_num), .i_w_addr(w_addr), .i_weight(weight),
        .o_x_ready(x_ready), .o_y_valid(y_valid), .o_y_num(y_num),
        .o_y_data(y_data), .o_layer_done(layer_done), .o_err(err)
    );

    typedef struct {
        int     num;
        longint data;
        bit     done;
        longint cyc;
    } exp_t;

    exp_t   exp_q[$];
    int     feat_m[NW];
    int     checks = 0;
    int     failures = 0;
    longint cyc = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic longint ref_y(input longint s);
        logic signed [AW-1:0] t;
        t = AW'(s);
`ifdef F6_RELU_EN
        if (t < 0) t = '0;
`endif
        return longint'(t);
    endfunction

    function automatic int pick(input int sel);
        logic signed [7:0] b;
        case (sel)
            0: return 1;
            1: return -128;
            2: return -1;
            default: begin
                b = 8'($urandom_range(0, 255));
                return int'(b);
            end
        endcase
    endfunction

    task automatic idle();
        @(posedge clk); #1;
        x_en = 1'b0;
        w_en = 1'b0;
    endtask

    task automatic load_features(input int sel);
        for (int i = 0; i < NW; i++) begin
            feat_m[i] = pick(sel);
            @(posedge clk); #1;
            w_en   = 1'b0;
            x_en   = 1'b1;
            x_addr = 8'(i);
            x_data = WD'(feat_m[i]);
        end
        idle();
        check("x_ready_low_in_run", longint'(x_ready), 0);
    endtask

    task automatic run_neuron(input int num_drv, input int sel, input int gap,
                              input int nbeats, input bit is_final);
        longint sum = 0;
        int     w;
        exp_t   e;
        for (int i = 0; i < nbeats; i++) begin
            if ($urandom_range(0, 99) < gap) idle();
            w = pick(sel);
            sum += longint'(feat_m[i]) * longint'(w);
            @(posedge clk); #1;
            x_en   = 1'b0;
            w_en   = 1'b1;
            w_num  = 8'(num_drv);
            w_addr = 8'(i);
            weight = WD'(w);
            if (i == NW - 1) begin
                e.num  = num_drv;
                e.data = ref_y(sum);
                e.done = is_final;
                e.cyc  = cyc + LAT;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic drain();
        int k = 0;
        while (exp_q.size() != 0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("drain_pending", longint'(exp_q.size()), 0);
        @(negedge clk);
        check("x_ready_after_layer", longint'(x_ready), 1);
    endtask

    task automatic run_layer(input int sel1, input int sel_rest, input int gap, input int skip_n);
        for (int n = 1; n <= NUM; n++) begin
            if (n == skip_n) check("err_before_skip", longint'(err), 0);
            run_neuron((n == skip_n) ? n + 1 : n, (n == 1) ? sel1 : sel_rest, gap, NW, n == NUM);
            if (n == skip_n) begin
                idle();
                check("err_after_skip", longint'(err), 1);
            end
        end
        idle();
        drain();
    endtask

    task automatic monitor();
        exp_t e;
        bit   done_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                done_prev = 1'b0;
            end else begin
                if (done_prev) check("x_ready_after_done", longint'(x_ready), 1);
                done_prev = layer_done;
                if (layer_done && !y_valid) check("layer_done_without_valid", 1, 0);
                if (y_valid) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_y_valid", longint'(y_num), -1);
                    end else begin
                        e = exp_q.pop_front();
                        $display("result neuron=%0d data=%0d done=%0d cycle=%0d",
                                 y_num, $signed(y_data), layer_done, cyc);
                        check("y_num", longint'(y_num), longint'(e.num));
                        check("y_data", longint'($signed(y_data)), e.data);
                        check("layer_done", longint'(layer_done), longint'(e.done));
                        check("latency_cycle", cyc, e.cyc);
                    end
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; x_en = 1'b0; w_en = 1'b0;
        x_addr = '0; x_data = '0; w_num = '0; w_addr = '0; weight = '0;
        fork
            monitor();
            begin
                repeat (3) @(posedge clk);
                #1;
                check("rst_x_ready", longint'(x_ready), 1);
                check("rst_y_valid", longint'(y_valid), 0);
                check("rst_layer_done", longint'(layer_done), 0);
                check("rst_err", longint'(err), 0);
                check("rst_y_data", longint'(y_data), 0);
                check("rst_y_num", longint'(y_num), 0);
                rst = 1'b0;

                // Layer 1: all ones, gapless.
                load_features(0);
                run_layer(0, 0, 0, 0);
                check("err_clean_layer", longint'(err), 0);

                // Layer 2: worst-case magnitude on neuron 1, random weights with gaps, neuron-index skip.
                load_features(1);
                run_layer(1, 3, 25, 2);
                check("err_sticky_layer2", longint'(err), 1);

                // Aborted layer: reset in the middle of neuron 40.
                load_features(3);
                for (int n = 1; n < 40; n++) run_neuron(n, 3, 20, NW, 1'b0);
                run_neuron(40, 3, 20, 60, 1'b0);
                @(posedge clk); #1;
                rst = 1'b1;
                w_en = 1'b0;
                exp_q.delete();
                repeat (2) @(posedge clk);
                #1;
                rst = 1'b0;
                check("err_cleared_by_reset", longint'(err), 0);
                check("x_ready_after_reset", longint'(x_ready), 1);

                // Weight beat in LOAD is a protocol error.
                @(posedge clk); #1;
                w_en = 1'b1; w_num = 8'd1; w_addr = 8'd0; weight = WD'(5);
                idle();
                check("err_w_in_load", longint'(err), 1);
                check("x_ready_hold_after_w_load", longint'(x_ready), 1);

                // Layer 3 after reset: ones with neuron 1 weights -1, the rest random.
                load_features(0);
                run_layer(2, 3, 20, 0);
                check("err_held_until_reset", longint'(err), 1);

                @(posedge clk); #1;
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                check("err_final_reset", longint'(err), 0);
                repeat (5) @(posedge clk);
            end
        join_any
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
